// File: rtl/fp2dec_seq.sv
// Sequencer for the positive-exponent float-to-decimal datapath.
// Accepts one (frac, exp) request, derives the 3k offset, then steps the
// power unit, the multiplier and the negative-k ALU in turn with a per-stage
// watchdog, and returns the outcome over a valid/ready handshake.
//
// Ports:
//   CLK3, RST            clock, asynchronous active-low reset
//   start, frac, exp     conversion request (sampled in IDLE only)
//   busy                 high from accept until the result handshake completes
//   pow_go, pow_exp      power unit start pulse and exponent operand (3k)
//   pow_done             power unit result valid (level)
//   mult_go, mult_done   multiplier start pulse / result valid (level)
//   negk_rst_n           active-low reset to the negative-k ALU
//   negk_done            negative-k ALU outputs valid (level)
//   lt_offset            3k, added downstream to the ALU's lt output
//   frac_q               latched mantissa
//   out_valid, out_ready result handshake
//   err                  qualifies out_valid: a stage timed out
module fp2dec_seq #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned NEGRST_CYC  = 2
) (
    input  logic        CLK3,
    input  logic        RST,
    input  logic        start,
    input  logic [22:0] frac,
    input  logic [8:0]  exp,
    output logic        busy,
    output logic        pow_go,
    output logic [8:0]  pow_exp,
    input  logic        pow_done,
    output logic        mult_go,
    input  logic        mult_done,
    output logic        negk_rst_n,
    input  logic        negk_done,
    output logic [8:0]  lt_offset,
    output logic [22:0] frac_q,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] NRST_LAST = TW'(NEGRST_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POW,
        S_MUL,
        S_NEGRST,
        S_NEG,
        S_DONE,
        S_ERR
    } state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic          busy_q;
    logic          pow_go_q;
    logic          mult_go_q;
    logic          negk_q;
    logic          out_valid_q;
    logic          err_q;
    logic [8:0]    k3_q;
    logic [22:0]   frac_lat_q;
    logic [8:0]    k3_d;

    // 3k = 2k + k, carry out of bit 8 dropped.
    assign k3_d = {exp[7:0], 1'b0} + exp;

    // Sequencer FSM; every output is a register. The go pulse registers double
    // as "first cycle in state" flags, where a stale done level is ignored.
    always_ff @(posedge CLK3 or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            pow_go_q    <= 1'b0;
            mult_go_q   <= 1'b0;
            negk_q      <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            k3_q        <= '0;
            frac_lat_q  <= '0;
        end else begin
            pow_go_q  <= 1'b0;
            mult_go_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    negk_q <= 1'b1;
                    if (start) begin
                        frac_lat_q <= frac;
                        k3_q       <= k3_d;
                        busy_q     <= 1'b1;
                        pow_go_q   <= 1'b1;
                        timer_q    <= '0;
                        state_q    <= S_POW;
                    end
                end
                S_POW: begin
                    if (!pow_go_q && pow_done) begin
                        mult_go_q <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= S_MUL;
                    end else if (timer_q == TMO_LAST) begin
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        state_q     <= S_ERR;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_MUL: begin
                    if (!mult_go_q && mult_done) begin
                        negk_q  <= 1'b0;
                        timer_q <= '0;
                        state_q <= S_NEGRST;
                    end else if (timer_q == TMO_LAST) begin
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        state_q     <= S_ERR;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_NEGRST: begin
                    if (timer_q == NRST_LAST) begin
                        negk_q  <= 1'b1;
                        timer_q <= '0;
                        state_q <= S_NEG;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_NEG: begin
                    if (negk_done) begin
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b0;
                        state_q     <= S_DONE;
                    end else if (timer_q == TMO_LAST) begin
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        state_q     <= S_ERR;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign pow_go     = pow_go_q;
    assign pow_exp    = k3_q;
    assign mult_go    = mult_go_q;
    assign negk_rst_n = negk_q;
    assign lt_offset  = k3_q;
    assign frac_q     = frac_lat_q;
    assign out_valid  = out_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_fp2dec_seq.sv
// Bench for fp2dec_seq: stage responders with chosen done delays, and a
// transaction-level model predicting latency, error, 3k and handshake behaviour.
module tb_fp2dec_seq;

    localparam int TMO  = 64;
    localparam int NRST = 2;

    logic        CLK3 = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [22:0] frac = '0;
    logic [8:0]  exp = '0;
    logic        busy;
    logic        pow_go;
    logic [8:0]  pow_exp;
    logic        pow_done = 1'b0;
    logic        mult_go;
    logic        mult_done = 1'b0;
    logic        negk_rst_n;
    logic        negk_done = 1'b0;
    logic [8:0]  lt_offset;
    logic [22:0] frac_q;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        err;

    fp2dec_seq #(.TIMEOUT_CYC(TMO), .NEGRST_CYC(NRST)) dut (
        .CLK3(CLK3), .RST(RST), .start(start), .frac(frac), .exp(exp),
        .busy(busy), .pow_go(pow_go), .pow_exp(pow_exp), .pow_done(pow_done),
        .mult_go(mult_go), .mult_done(mult_done), .negk_rst_n(negk_rst_n),
        .negk_done(negk_done), .lt_offset(lt_offset), .frac_q(frac_q),
        .out_valid(out_valid), .out_ready(out_ready), .err(err)
    );

    always #5 CLK3 = ~CLK3;

    int n_tests = 0;
    int n_fail  = 0;

    // responder bookkeeping: cycles elapsed in each stage (1 = first cycle)
    int pc, mc, nc;
    bit nseen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK3);
        #1;
    endtask

    // Stage models: each raises its done level once it has spent d cycles in the stage.
    task automatic respond(input int dp, input int dm, input int dn);
        if (pow_go) pc = 1; else if (pc > 0) pc++;
        if (mult_go) mc = 1; else if (mc > 0) mc++;
        if (!negk_rst_n) begin nseen = 1; nc = 0; end
        else if (nseen) nc++;
        pow_done  = (pc > 0) && (pc >= dp);
        mult_done = (mc > 0) && (mc >= dm);
        negk_done = (nc > 0) && (nc >= dn);
    endtask

    // One full conversion. Called with the bench in IDLE; the current cycle is the accept cycle.
    task automatic run_conv(input logic [8:0] e, input logic [22:0] f, input int dp, input int dm,
                            input int dn, input int rdly, input bit keep);
        logic [8:0] k3x;
        int ep, em, en, xlat, c, npg, nmg, nlow;
        bit xerr, got_v, busy_ok;

        // model: stage durations, POW/MUL ignore done in their first cycle
        k3x = 9'((int'(e) * 3) % 512);
        ep = (dp < 2) ? 2 : dp;
        em = (dm < 2) ? 2 : dm;
        en = (dn < 1) ? 1 : dn;
        if (ep > TMO)      begin xerr = 1; xlat = 1 + TMO; end
        else if (em > TMO) begin xerr = 1; xlat = 1 + ep + TMO; end
        else if (en > TMO) begin xerr = 1; xlat = 1 + ep + em + NRST + TMO; end
        else               begin xerr = 0; xlat = 1 + ep + em + NRST + en; end

        pc = 0; mc = 0; nc = 0; nseen = 0;
        pow_done = 0; mult_done = 0; negk_done = 0;
        exp = e; frac = f; start = 1'b1; out_ready = 1'b0;
        c = 0; npg = 0; nmg = 0; nlow = 0; got_v = 0; busy_ok = 1;

        while (!got_v && c < 400) begin
            tick();
            c++;
            if (!keep) start = 1'($urandom);
            exp  = 9'($urandom);
            frac = 23'($urandom);
            if (pow_go) npg++;
            if (mult_go) nmg++;
            if (!negk_rst_n) nlow++;
            if (!busy) busy_ok = 0;
            respond(dp, dm, dn);
            if (out_valid) got_v = 1;
        end

        check_eq("valid_seen", 32'(got_v), 32'd1);
        check_eq("latency", 32'(c), 32'(xlat));
        check_eq("err", 32'(err), 32'(xerr));
        check_eq("lt_offset", 32'(lt_offset), 32'(k3x));
        check_eq("pow_exp", 32'(pow_exp), 32'(k3x));
        check_eq("frac_q", 32'(frac_q), 32'(f));
        check_eq("pow_go_cnt", 32'(npg), 32'd1);
        check_eq("mult_go_cnt", 32'(nmg), (ep <= TMO) ? 32'd1 : 32'd0);
        check_eq("negk_low_cnt", 32'(nlow), (ep <= TMO && em <= TMO) ? 32'(NRST) : 32'd0);
        check_eq("busy_held", 32'(busy_ok), 32'd1);

        // backpressure window with start noise
        for (int i = 0; i < rdly; i++) begin
            out_ready = 1'b0;
            start = keep ? 1'b1 : 1'($urandom);
            tick();
            check_eq("bp_valid", 32'(out_valid), 32'd1);
            check_eq("bp_err", 32'(err), 32'(xerr));
            check_eq("bp_busy", 32'(busy), 32'd1);
            check_eq("bp_no_go", 32'(pow_go), 32'd0);
            check_eq("bp_k3", 32'(lt_offset), 32'(k3x));
            check_eq("bp_frac", 32'(frac_q), 32'(f));
        end

        // handshake; a start in this same cycle must not be taken
        out_ready = 1'b1;
        start = keep ? 1'b1 : 1'($urandom);
        tick();
        out_ready = 1'b0;
        check_eq("hs_valid", 32'(out_valid), 32'd0);
        check_eq("hs_busy", 32'(busy), 32'd0);
        check_eq("hs_err", 32'(err), 32'd0);
        check_eq("hs_no_go", 32'(pow_go), 32'd0);
        if (!keep) begin
            start = 1'b0;
            tick();
            check_eq("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int mode, dp, dm, dn;

        // power-on reset
        tick();
        tick();
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_negk", 32'(negk_rst_n), 32'd0);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_pow_go", 32'(pow_go), 32'd0);
        check_eq("rst_mult_go", 32'(mult_go), 32'd0);
        check_eq("rst_k3", 32'(lt_offset), 32'd0);
        check_eq("rst_frac", 32'(frac_q), 32'd0);
        RST = 1'b1;
        tick();
        check_eq("rel_negk", 32'(negk_rst_n), 32'd1);

        // reset asserted mid-POW aborts silently
        exp = 9'd7; frac = 23'h12345; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("midpow_busy", 32'(busy), 32'd1);
        RST = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_negk", 32'(negk_rst_n), 32'd0);
        check_eq("arst_go", 32'(pow_go), 32'd0);
        tick();
        check_eq("arst_negk_hold", 32'(negk_rst_n), 32'd0);
        RST = 1'b1;
        tick();
        check_eq("rel2_negk", 32'(negk_rst_n), 32'd1);
        check_eq("rel2_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check_eq("rel2_no_valid", 32'(out_valid), 32'd0);
        end

        // directed: nominal, wraps, timeouts, backpressure, back-to-back
        run_conv(9'd5, 23'h400000, 0, 0, 0, 0, 0);
        run_conv(9'd200, 23'h000001, 2, 2, 1, 1, 0);
        run_conv(9'h1FF, 23'h7FFFFF, 3, 1, 2, 0, 0);
        run_conv(9'd33, 23'h2AAAAA, 2, 1000, 1, 0, 0);
        run_conv(9'd34, 23'h155555, 2, 65, 1, 2, 0);
        run_conv(9'd35, 23'h0F0F0F, 2, 64, 1, 0, 0);
        run_conv(9'd36, 23'h00FF00, 1000, 2, 1, 0, 0);
        run_conv(9'd37, 23'h3C3C3C, 2, 2, 1000, 0, 0);
        run_conv(9'd38, 23'h3C3C3C, 2, 2, 64, 0, 0);
        run_conv(9'd99, 23'h654321, 4, 3, 5, 10, 0);
        run_conv(9'd100, 23'h111111, 0, 0, 0, 0, 1);
        run_conv(9'd300, 23'h222222, 5, 6, 2, 3, 1);
        run_conv(9'd400, 23'h333333, 2, 2, 1, 0, 0);

        // randomized conversions
        for (int n = 0; n < 30; n++) begin
            mode = int'($urandom_range(0, 9));
            dp = int'($urandom_range(0, 6));
            dm = int'($urandom_range(0, 6));
            dn = int'($urandom_range(0, 6));
            if (mode == 0) dp = int'($urandom_range(60, 70));
            if (mode == 1) dm = int'($urandom_range(60, 70));
            if (mode == 2) dn = int'($urandom_range(60, 70));
            run_conv(9'($urandom), 23'($urandom), dp, dm, dn,
                     int'($urandom_range(0, 5)), 1'($urandom));
        end
        start = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp2dec_seq.md
Name: fp2dec_seq

Overview:
- Sequencer for the positive-exponent float-to-decimal datapath. Replaces clock-enable gating of the power, multiply and negative-k stages with an explicit FSM.
- Accepts one conversion request (frac, exp) and computes the 3k offset.
- Issues start pulses to the power unit and multiplier, pulses the negative-k ALU reset, then waits for each stage's done.
- Presents a valid/ready result handshake with a per-stage watchdog.

Parameters:
- TIMEOUT_CYC, 64: maximum cycles any stage may take before the conversion aborts with an error.
- NEGRST_CYC, 2: cycles negk_rst_n is held low before the negative-k ALU runs.

Ports:
- CLK3 in 1: clock.
- RST in 1: reset, asynchronous, active-low.
- start in 1: conversion request; sampled in IDLE only.
- frac in 23: mantissa of the operand.
- exp in 9: unbiased exponent k.
- busy out 1: high from the accept cycle until the result handshake completes.
- pow_go out 1: one-cycle start pulse to the power unit.
- pow_exp out 9: exponent operand to the power unit (k3_reg).
- pow_done in 1: power unit result valid (level).
- mult_go out 1: one-cycle start pulse to the multiplier.
- mult_done in 1: multiplier result valid (level).
- negk_rst_n out 1: active-low reset to the negative-k ALU.
- negk_done in 1: negative-k ALU outputs valid (level).
- lt_offset out 9: k3_reg, added downstream to the ALU's lt output.
- frac_q out 23: latched frac, feeds the datapath.
- out_valid out 1: result (or error) available.
- out_ready in 1: consumer accepts the result.
- err out 1: qualifies out_valid; 1 means a stage timed out.

Behaviour:
- Reset (RST low, asynchronous): state=IDLE; busy=0, pow_go=0, mult_go=0, out_valid=0, err=0; negk_rst_n=0; k3_reg=0, frac_q=0, timer=0.
- negk_rst_n is driven low combinationally while RST is low. Reset mid-conversion aborts with no output.
- k3 = ({exp[7:0],1'b0} + exp) mod 512, 9-bit; carry out is discarded.
- IDLE:
  - negk_rst_n=1.
  - If start=1: latch frac_q=frac and k3_reg=k3, set busy=1, go to POW.
  - start while busy is ignored; no queuing.
- POW:
  - pow_go=1 for exactly the first cycle in the state; timer is cleared on entry.
  - pow_done is sampled from the second cycle in the state onward. pow_done=1 -> MUL.
  - Otherwise timer increments; timer==TIMEOUT_CYC-1 with no done -> ERR.
- MUL: same rules as POW, using mult_go and mult_done. Done -> NEGRST.
- NEGRST:
  - negk_rst_n=0 for NEGRST_CYC cycles, counted by the timer, then -> NEG.
  - negk_rst_n is 1 in every other state except reset.
- NEG:
  - Wait for negk_done, sampled from the first cycle in the state; same timeout rule.
  - Done -> DONE.
- DONE:
  - out_valid=1, err=0.
  - On out_valid && out_ready: out_valid=0, busy=0 next cycle, go to IDLE.
  - frac_q, k3_reg and lt_offset hold until the handshake completes.
- ERR: out_valid=1, err=1; same handshake as DONE. err clears with out_valid.
- Simultaneous events:
  - done and timeout in the same cycle: done wins.
  - out_ready while out_valid=0: ignored.
  - start in the same cycle as the accepting handshake: ignored; start is accepted from IDLE on the following cycle.
- Minimum latency, accept to out_valid, with all done signals returned at earliest: 1 (accept) + 2 (POW) + 2 (MUL) + NEGRST_CYC + 1 (NEG) = 8 cycles at defaults.
- Timer width is clog2(TIMEOUT_CYC+1); it never wraps, because the timeout exits the state first.

Test Plan:
- Reset check: drive RST low mid-POW -> state IDLE, busy=0, negk_rst_n=0 while RST is low. Release RST -> negk_rst_n=1 and no out_valid.
- Nominal, exp=9'd5, frac=23'h400000, stage dones returned at the earliest cycle -> pow_go pulse of one cycle, lt_offset=9'd15, negk_rst_n low for exactly 2 cycles. out_valid rises 8 cycles after accept with err=0.
- Wrap: exp=9'd200 -> k3_reg=9'd88 (600 mod 512). Drive exp=9'h1FF -> k3=9'h1FD.
- Timeout: withhold mult_done -> ERR after 64 MUL cycles with out_valid=1, err=1. A mult_done arriving on cycle 64 instead -> no error.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable and busy=1. Pulse start during that window -> ignored. Raise out_ready -> IDLE next cycle.
- Back-to-back: start held high -> second conversion accepted exactly one cycle after the first handshake completes, and its results are independent of the first.
